// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming (7,4) receive/decode path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: CODE_W / DATA_W widths and the serial framer state enum.
package hamming_pkg;

   localparam int CODE_W = 7;
   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } rx_state_t;

endpackage

// File: rtl/hamming_code_fifo.sv
// Synchronous first-word-fall-through FIFO holding assembled codewords.
// Latency: a push is visible at dout/empty the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high); push/din write side; pop/dout read side;
//        full, empty, count (occupancy, one bit wider than the pointers).
module hamming_code_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop on an empty FIFO is ignored; a pop frees a slot for a
   // simultaneous push even when full.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head entry shown directly. While empty, rd_ptr sits on a slot that is
   // only rewritten by the push that makes the FIFO non-empty again, so the
   // output does not move while empty.
   assign dout = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial framer: start bit, CODE_W data bits LSB first, stop bit -> codeword FIFO.
// Latency: codeword valid 1 cycle after the stop-bit sample edge (empty FIFO).
// Backpressure: code_valid/code_ready; frames completing into a full FIFO are dropped.
// Ports: clk, rst (sync, active-high); bit_in/bit_en serial line + sample strobe;
//        code_out/code_valid/code_ready head-of-FIFO handshake; frame_err and
//        overflow one-cycle pulses; drop_count saturating drops; busy = not IDLE.
module hamming_serial_rx #(
   parameter int FIFO_DEPTH = 4,
   parameter int CODE_W     = hamming_pkg::CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_en,
   output logic [CODE_W-1:0] code_out,
   output logic              code_valid,
   input  logic              code_ready,
   output logic              frame_err,
   output logic              overflow,
   output logic [7:0]        drop_count,
   output logic              busy
);

   import hamming_pkg::*;

   localparam int CNT_W = $clog2(CODE_W);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   rx_state_t         state;
   rx_state_t         state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CODE_W-1:0] shift;
   logic [CODE_W-1:0] shift_nxt;
   logic              push;
   logic              ferr_nxt;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [OCC_W-1:0]  fifo_count;
   logic              unused_count;

   // Occupancy is not needed here; full/empty carry everything the framer uses.
   assign unused_count = ^fifo_count;

   assign code_valid = ~fifo_empty;
   assign pop        = code_valid & code_ready;
   // A pop in the same cycle makes room, so only a push into a full FIFO
   // with no concurrent pop loses the codeword.
   assign drop       = push & fifo_full & ~pop;
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift;
      push      = 1'b0;
      ferr_nxt  = 1'b0;
      if (bit_en) begin
         unique case (state)
            IDLE: begin
               if (!bit_in) begin
                  cnt_nxt   = '0;
                  state_nxt = DATA;
               end
            end
            DATA: begin
               shift_nxt[cnt] = bit_in;
               cnt_nxt        = cnt + CNT_W'(1);
               if (cnt == CNT_W'(CODE_W - 1)) begin
                  state_nxt = STOP;
               end
            end
            STOP: begin
               // A 0 stop bit is a framing error, not the next start bit.
               if (bit_in) begin
                  push = 1'b1;
               end else begin
                  ferr_nxt = 1'b1;
               end
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift     <= shift_nxt;
         frame_err <= ferr_nxt;
         overflow  <= drop;
         if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

   hamming_code_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (shift),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (code_out),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx: frame-level model (queue of codewords) checked every cycle.
// Latency: n/a.
// Backpressure: code_ready driven low, random or high depending on the phase.
module tb_hamming_serial_rx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b1;
   logic       bit_en = 1'b0;
   logic       code_ready = 1'b0;
   logic [6:0] code_out;
   logic       code_valid;
   logic       frame_err;
   logic       overflow;
   logic [7:0] drop_count;
   logic       busy;

   always #5 clk = ~clk;

   hamming_serial_rx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_en     (bit_en),
      .code_out   (code_out),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .drop_count (drop_count),
      .busy       (busy)
   );

   int errors = 0;
   int checks = 0;

   // What the sender is doing on the upcoming sample edge.
   logic       ev_start = 1'b0;
   logic       ev_stop = 1'b0;
   logic       ev_stopbit = 1'b0;
   logic [6:0] ev_code = '0;
   int         rdy_mode = 0;   // 0: ready low, 1: random, 2: ready high

   // Frame-level model: completed codewords in a bounded queue.
   logic [6:0] mq[$];
   logic       m_busy = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovf = 1'b0;
   int         m_drops = 0;
   bit         check_en = 1'b0;

   logic [6:0] codes [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit popped;
      if (rst) begin
         mq.delete();
         m_busy  = 1'b0;
         m_ferr  = 1'b0;
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         popped = code_ready && (mq.size() > 0);
         m_ferr = 1'b0;
         m_ovf  = 1'b0;
         if (popped) void'(mq.pop_front());
         if (ev_start) m_busy = 1'b1;
         if (ev_stop) begin
            m_busy = 1'b0;
            if (!ev_stopbit) m_ferr = 1'b1;
            else if (mq.size() < DEPTH) mq.push_back(ev_code);
            else begin
               m_ovf = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("code_valid", code_valid, mq.size() > 0);
         if (mq.size() > 0) check("code_out", code_out, mq[0]);
         check("frame_err", frame_err, m_ferr);
         check("overflow", overflow, m_ovf);
         check("drop_count", drop_count, m_drops);
         check("busy", busy, m_busy);
      end
   end

   task automatic set_ready();
      case (rdy_mode)
         0:       code_ready = 1'b0;
         1:       code_ready = 1'($urandom_range(0, 1));
         default: code_ready = 1'b1;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         bit_en = 1'b0;
         bit_in = 1'($urandom_range(0, 1));
         set_ready();
         tick();
      end
      bit_en = 1'b0;
   endtask

   task automatic strobe(input logic b, input logic st, input logic sp,
                         input logic [6:0] code, input int rdy_ovr);
      bit_en     = 1'b1;
      bit_in     = b;
      ev_start   = st;
      ev_stop    = sp;
      ev_stopbit = b;
      ev_code    = code;
      set_ready();
      if (rdy_ovr >= 0) code_ready = rdy_ovr[0];
      tick();
      bit_en   = 1'b0;
      ev_start = 1'b0;
      ev_stop  = 1'b0;
      bit_in   = 1'b1;
   endtask

   task automatic send_frame(input logic [6:0] code, input logic stopbit,
                             input int maxgap, input int rdy_at_stop);
      gap($urandom_range(0, maxgap));
      strobe(1'b0, 1'b1, 1'b0, code, -1);
      for (int i = 0; i < 7; i++) begin
         gap($urandom_range(0, maxgap));
         strobe(code[i], 1'b0, 1'b0, code, -1);
      end
      gap($urandom_range(0, maxgap));
      strobe(stopbit, 1'b0, 1'b1, code, rdy_at_stop);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", code_valid, 0);
      check("rst_code_out", code_out, 0);
      check("rst_busy", busy, 0);
      check("rst_drops", drop_count, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovf", overflow, 0);
      check_en = 1'b1;
      rst = 1'b0;
      gap(2);

      // Plain frame 0,1,0,1,0,1,0,1,1.
      rdy_mode = 0;
      send_frame(7'h55, 1'b1, 0, -1);
      check("lit_55_valid", code_valid, 1);
      check("lit_55_code", code_out, 7'h55);
      check("lit_55_ferr", frame_err, 0);
      check("lit_55_ovf", overflow, 0);
      rdy_mode = 2;
      gap(1);
      check("lit_55_drained", code_valid, 0);

      // Bad stop bit.
      rdy_mode = 0;
      send_frame(7'h0F, 1'b0, 0, -1);
      check("lit_ferr_pulse", frame_err, 1);
      check("lit_ferr_valid", code_valid, 0);
      check("lit_ferr_busy", busy, 0);
      gap(1);
      check("lit_ferr_done", frame_err, 0);

      // Six frames into a 4-deep FIFO with no consumer.
      for (int i = 0; i < 6; i++) begin
         codes[i] = 7'($urandom);
         send_frame(codes[i], 1'b1, 1, -1);
      end
      check("lit_ovf_drops", drop_count, 2);
      for (int i = 0; i < 4; i++) begin
         check("lit_drain_order", code_out, codes[i]);
         code_ready = 1'b1;
         tick();
         code_ready = 1'b0;
      end
      check("lit_drain_empty", code_valid, 0);

      // Fifth frame completes while full with a pop in the same cycle.
      for (int i = 0; i < 5; i++) begin
         codes[i] = 7'($urandom);
         send_frame(codes[i], 1'b1, 0, (i == 4) ? 1 : -1);
      end
      check("lit_full_pop_ovf", overflow, 0);
      check("lit_full_pop_drops", drop_count, 2);
      for (int i = 1; i < 5; i++) begin
         check("lit_full_pop_order", code_out, codes[i]);
         code_ready = 1'b1;
         tick();
         code_ready = 1'b0;
      end
      check("lit_full_pop_empty", code_valid, 0);

      // Reset in the middle of a frame.
      strobe(1'b0, 1'b1, 1'b0, 7'h00, -1);
      for (int i = 0; i < 3; i++) strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, 7'h00, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("lit_midrst_busy", busy, 0);
      check("lit_midrst_drops", drop_count, 0);
      send_frame(7'h2A, 1'b1, 0, -1);
      check("lit_2a_valid", code_valid, 1);
      check("lit_2a_code", code_out, 7'h2A);
      check("lit_2a_ferr", frame_err, 0);
      check("lit_2a_ovf", overflow, 0);
      rdy_mode = 2;
      gap(1);
      check("lit_2a_only", code_valid, 0);

      // Random gaps, line toggling between strobes, random consumer.
      rdy_mode = 1;
      repeat (40) begin
         repeat ($urandom_range(0, 2)) strobe(1'b1, 1'b0, 1'b0, 7'h00, -1);
         send_frame(7'($urandom), ($urandom_range(0, 7) != 0), 5, -1);
      end
      rdy_mode = 2;
      gap(8);

      // Drop counter saturation.
      rdy_mode = 0;
      repeat (262) send_frame(7'($urandom), 1'b1, 0, -1);
      check("lit_drops_sat", drop_count, 255);
      rdy_mode = 2;
      gap(6);

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
